l15_req_arbiter: RTL
====================

Name: l15_req_arbiter

Overview:
- Shares the single L1.5 (OpenPiton NoC) request port between the instruction-cache miss path and the write-through data-cache path.
- Round-robin arbitration, with one registered output stage that sustains one request per cycle.
- Throttles dcache stores/AMOs against an outstanding-store budget.
- Holds non-cacheable dcache loads until all earlier stores are acknowledged.

Parameters:
- MaxOutstandingStores, 7, max stores/AMOs granted but not yet acknowledged by L1.5.
- AddrWidth, 64, request address width.
- DataWidth, 64, store/AMO data width.
- TidWidth, 2, transaction ID width.
- CntWidth, $clog2(MaxOutstandingStores+1), store counter width (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- icache_req_valid_i  in  1  icache miss request valid
- icache_req_ready_o  out  1  icache request granted this cycle
- icache_req_addr_i  in  AddrWidth  icache fill address
- icache_req_tid_i  in  TidWidth  icache transaction ID
- dcache_req_valid_i  in  1  dcache request valid
- dcache_req_ready_o  out  1  dcache request granted this cycle
- dcache_req_type_i  in  2  00 load, 01 store, 10 AMO, 11 reserved (never granted)
- dcache_req_nc_i  in  1  non-cacheable access
- dcache_req_addr_i  in  AddrWidth  dcache address
- dcache_req_data_i  in  DataWidth  store/AMO data
- dcache_req_size_i  in  3  log2 access size
- dcache_req_tid_i  in  TidWidth  dcache transaction ID
- l15_req_valid_o  out  1  request to L1.5 valid
- l15_req_ready_i  in  1  L1.5 accepts request
- l15_req_src_o  out  1  0 = icache, 1 = dcache
- l15_req_type_o  out  2  type; icache requests are driven as 00
- l15_req_nc_o  out  1  non-cacheable (0 for icache)
- l15_req_addr_o  out  AddrWidth  address
- l15_req_data_o  out  DataWidth  data (0 for icache and loads)
- l15_req_size_o  out  3  size (icache drives 3'b100, one line)
- l15_req_tid_o  out  TidWidth  transaction ID
- store_ack_i  in  1  one-cycle pulse; L1.5 acknowledged one store/AMO
- stores_outstanding_o  out  CntWidth  current store counter
- stores_idle_o  out  1  counter == 0
- ack_underflow_o  out  1  sticky: store_ack_i received while counter == 0

Behaviour:

Reset values:
- All outputs 0, except stores_idle_o = 1.
- Output register EMPTY.
- Round-robin pointer set so icache wins the first tie.

Output stage:
- Two states: EMPTY and FULL.
- load = winner exists AND (EMPTY OR l15_req_ready_i).
- EMPTY: on load go to FULL.
- FULL with l15_req_ready_i: load → stay FULL with new payload; no winner → EMPTY.
- FULL without ready: hold. Payload and valid must stay stable until accepted.
- Latency: request valid at cycle N → l15_req_valid_o at N+1. Back-to-back accepted requests give throughput 1/cycle.

Eligibility:
- icache: always eligible when valid.
- dcache store/AMO: eligible only if counter < MaxOutstandingStores.
- dcache load with nc=1: eligible only if counter == 0.
- dcache cacheable load: always eligible.
- dcache type 11: never eligible.

Arbitration and grant:
- Both eligible: grant the source not granted last. The pointer updates only on a grant.
- *_req_ready_o is combinational and equals (load AND source is winner).
- At most one ready is high per cycle.
- A requester must hold valid and payload until its ready is seen.

Store counter:
- +1 on the cycle a dcache store/AMO is granted (loaded into the output register).
- −1 on store_ack_i.
- Grant and ack in the same cycle: net unchanged.
- Ack at 0: counter stays 0 and ack_underflow_o is set to 1 until reset.
- The counter never exceeds MaxOutstandingStores.

Reset mid-operation:
- An unaccepted output is dropped; valid goes low the next cycle.
- Counter, sticky flag and pointer return to their reset values.

Test Plan:
- Both sources valid continuously, ready = 1 → grants alternate I, D, I, D starting with icache; l15_req_valid_o high every cycle from cycle 1.
- Hold l15_req_ready_i = 0 for 5 cycles with a dcache store pending → payload stable, dcache_req_ready_o = 0 after the first grant, counter = 1.
- Issue 8 dcache stores with no acks → 7 granted, 8th stalled, stores_outstanding_o = 7; one store_ack_i → 8th granted next cycle, counter stays 7.
- Counter = 2, nc load valid → blocked; a cacheable icache request still passes; two acks → nc load granted the cycle after the counter reaches 0.
- Store grant and store_ack_i in the same cycle with counter = 3 → counter stays 3. store_ack_i at counter 0 → ack_underflow_o = 1 and sticky.
- rst_i asserted while FULL and not ready → l15_req_valid_o = 0, counter = 0, stores_idle_o = 1 next cycle; first grant after reset goes to icache.

Source files
------------

// File: rtl/l15_req_arbiter.sv
// Round-robin arbiter sharing the L1.5 request port between icache and dcache,
// with a registered output stage, a store-credit counter and nc-load ordering.
module l15_req_arbiter #(
    parameter int unsigned MaxOutstandingStores = 7,
    parameter int unsigned AddrWidth            = 64,
    parameter int unsigned DataWidth            = 64,
    parameter int unsigned TidWidth             = 2,
    parameter int unsigned CntWidth             = $clog2(MaxOutstandingStores + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 icache_req_valid_i,
    output logic                 icache_req_ready_o,
    input  logic [AddrWidth-1:0] icache_req_addr_i,
    input  logic [TidWidth-1:0]  icache_req_tid_i,
    input  logic                 dcache_req_valid_i,
    output logic                 dcache_req_ready_o,
    input  logic [1:0]           dcache_req_type_i,
    input  logic                 dcache_req_nc_i,
    input  logic [AddrWidth-1:0] dcache_req_addr_i,
    input  logic [DataWidth-1:0] dcache_req_data_i,
    input  logic [2:0]           dcache_req_size_i,
    input  logic [TidWidth-1:0]  dcache_req_tid_i,
    output logic                 l15_req_valid_o,
    input  logic                 l15_req_ready_i,
    output logic                 l15_req_src_o,
    output logic [1:0]           l15_req_type_o,
    output logic                 l15_req_nc_o,
    output logic [AddrWidth-1:0] l15_req_addr_o,
    output logic [DataWidth-1:0] l15_req_data_o,
    output logic [2:0]           l15_req_size_o,
    output logic [TidWidth-1:0]  l15_req_tid_o,
    input  logic                 store_ack_i,
    output logic [CntWidth-1:0]  stores_outstanding_o,
    output logic                 stores_idle_o,
    output logic                 ack_underflow_o
);

    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstandingStores);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    state_t              state;
    logic                dcache_prio;
    logic [CntWidth-1:0] store_cnt;

    logic d_is_store;
    logic d_elig;
    logic i_elig;
    logic win_d;
    logic win_i;
    logic load;
    logic store_grant;

    always_comb begin
        d_is_store = (dcache_req_type_i == 2'b01) || (dcache_req_type_i == 2'b10);
        unique case (dcache_req_type_i)
            2'b00:        d_elig = dcache_req_valid_i && (!dcache_req_nc_i || (store_cnt == '0));
            2'b01, 2'b10: d_elig = dcache_req_valid_i && (store_cnt < MaxCnt);
            default:      d_elig = 1'b0;
        endcase
        i_elig      = icache_req_valid_i;
        win_d       = d_elig && (!i_elig || dcache_prio);
        win_i       = i_elig && !win_d;
        load        = (win_i || win_d) && ((state == EMPTY) || l15_req_ready_i);
        store_grant = load && win_d && d_is_store;
    end

    assign icache_req_ready_o   = load && win_i;
    assign dcache_req_ready_o   = load && win_d;
    assign l15_req_valid_o      = (state == FULL);
    assign stores_outstanding_o = store_cnt;
    assign stores_idle_o        = (store_cnt == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= EMPTY;
            dcache_prio     <= 1'b0;
            store_cnt       <= '0;
            ack_underflow_o <= 1'b0;
            l15_req_src_o   <= 1'b0;
            l15_req_type_o  <= '0;
            l15_req_nc_o    <= 1'b0;
            l15_req_addr_o  <= '0;
            l15_req_data_o  <= '0;
            l15_req_size_o  <= '0;
            l15_req_tid_o   <= '0;
        end else begin
            if (load) begin
                state       <= FULL;
                dcache_prio <= win_i;
                if (win_i) begin
                    l15_req_src_o  <= 1'b0;
                    l15_req_type_o <= 2'b00;
                    l15_req_nc_o   <= 1'b0;
                    l15_req_addr_o <= icache_req_addr_i;
                    l15_req_data_o <= '0;
                    l15_req_size_o <= 3'b100;
                    l15_req_tid_o  <= icache_req_tid_i;
                end else begin
                    l15_req_src_o  <= 1'b1;
                    l15_req_type_o <= dcache_req_type_i;
                    l15_req_nc_o   <= dcache_req_nc_i;
                    l15_req_addr_o <= dcache_req_addr_i;
                    l15_req_data_o <= d_is_store ? dcache_req_data_i : '0;
                    l15_req_size_o <= dcache_req_size_i;
                    l15_req_tid_o  <= dcache_req_tid_i;
                end
            end else if ((state == FULL) && l15_req_ready_i) begin
                state <= EMPTY;
            end

            // A grant and an ack in the same cycle cancel; an ack at zero only flags.
            unique case ({store_grant, store_ack_i})
                2'b10: store_cnt <= store_cnt + CntOne;
                2'b01: begin
                    if (store_cnt != '0) store_cnt <= store_cnt - CntOne;
                    else                 ack_underflow_o <= 1'b1;
                end
                default: store_cnt <= store_cnt;
            endcase
        end
    end

endmodule
